// File: rtl/stream_mux_rr_pkg.sv
// Shared types for the round-robin stream multiplexer.
// Only the select-mode encoding lives here; widths are derived locally.
package stream_mux_rr_pkg;

  typedef enum logic {
    ModeRr    = 1'b0,
    ModeFixed = 1'b1
  } mode_e;

endpackage

// File: rtl/stream_mux_rr_arbiter.sv
// Combinational rotating-priority arbiter: the first requester at or after ptr wins,
// scanning upward and wrapping modulo N.
module rr_arbiter #(
  parameter int unsigned N = 4,
  localparam int unsigned CW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [CW-1:0] ptr,
  output logic [CW-1:0] gnt_idx,
  output logic          gnt_vld
);

  int unsigned idx;

  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = (32'(ptr) + k) % N;
      if (!gnt_vld && req[idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = CW'(idx);
      end
    end
  end

endmodule

// File: rtl/stream_mux_rr.sv
// N-channel valid/ready stream mux with a registered output stage.
// Channel choice comes from round-robin arbitration or an external fixed select.
module stream_mux_rr
  import stream_mux_rr_pkg::*;
#(
  parameter int unsigned N = 4,
  parameter int unsigned W = 8,
  localparam int unsigned CW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            mode,
  input  logic [CW-1:0]   sel,
  input  logic [N-1:0]    in_valid,
  input  logic [N*W-1:0]  in_data,
  output logic [N-1:0]    in_ready,
  output logic            out_valid,
  output logic [W-1:0]    out_data,
  output logic [CW-1:0]   out_ch,
  input  logic            out_ready
);

  logic [CW-1:0] ptr_q, ptr_d;
  logic [CW-1:0] rr_idx, g;
  logic          rr_vld, gv;
  logic          ld, xfer;
  logic          out_valid_q;
  logic [W-1:0]  out_data_q;
  logic [CW-1:0] out_ch_q;

  rr_arbiter #(
    .N(N)
  ) u_arb (
    .req     (in_valid),
    .ptr     (ptr_q),
    .gnt_idx (rr_idx),
    .gnt_vld (rr_vld)
  );

  // Fixed mode overrides the arbiter; an out-of-range select grants nothing.
  always_comb begin
    g  = rr_idx;
    gv = rr_vld;
    if (mode_e'(mode) == ModeFixed) begin
      g  = sel;
      gv = 1'b0;
      if (32'(sel) < N) begin
        gv = in_valid[sel];
      end
    end
  end

  assign ld   = !out_valid_q || out_ready;
  assign xfer = rst_n && ld && gv;

  always_comb begin
    in_ready = '0;
    for (int unsigned i = 0; i < N; i++) begin
      in_ready[i] = xfer && (g == CW'(i));
    end
  end

  assign ptr_d = (32'(g) == N - 1) ? '0 : g + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      ptr_q       <= '0;
    end else begin
      if (ld) begin
        out_valid_q <= gv;
        if (gv) begin
          out_data_q <= in_data[32'(g) * W +: W];
          out_ch_q   <= g;
        end
      end
      if (xfer) begin
        ptr_q <= ptr_d;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed bench for stream_mux_rr: expected beats are queued when an accept is
// predicted and compared when the output register drains them.
module tb_stream_mux_rr;

  localparam int unsigned N  = 4;
  localparam int unsigned W  = 8;
  localparam int unsigned CW = 2;

  typedef struct packed {
    logic [CW-1:0] ch;
    logic [W-1:0]  data;
  } beat_t;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            mode;
  logic [CW-1:0]   sel;
  logic [N-1:0]    in_valid;
  logic [N*W-1:0]  in_data;
  logic [N-1:0]    in_ready;
  logic            out_valid;
  logic [W-1:0]    out_data;
  logic [CW-1:0]   out_ch;
  logic            out_ready;

  int    checks = 0;
  int    errors = 0;
  beat_t sb[$];

  always #5 clk = ~clk;

  stream_mux_rr #(
    .N(N),
    .W(W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .sel       (sel),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_ready (out_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called just after an edge with inputs already driven; ends just after the next edge.
  task automatic cycle(input string tag, input logic [N-1:0] exp_rdy, input logic exp_ov);
    beat_t b;
    #1;
    chk({tag, " in_ready"}, 32'(in_ready), 32'(exp_rdy));
    chk({tag, " out_valid"}, 32'(out_valid), 32'(exp_ov));
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      chk({tag, " beat_expected"}, 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        b = sb.pop_front();
        chk({tag, " out_ch"}, 32'(out_ch), 32'(b.ch));
        chk({tag, " out_data"}, 32'(out_data), 32'(b.data));
      end
    end
    for (int i = 0; i < N; i++) begin
      if (exp_rdy[i]) begin
        b.ch   = CW'(i);
        b.data = in_data[i*W +: W];
        sb.push_back(b);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    mode      = 1'b0;
    sel       = '0;
    in_valid  = 4'b1111;
    in_data   = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    out_ready = 1'b1;

    // Reset with every channel valid
    @(posedge clk);
    #1;
    cycle("rst0", 4'b0000, 1'b0);
    cycle("rst1", 4'b0000, 1'b0);
    chk("rst out_data", 32'(out_data), 32'h0);
    chk("rst out_ch", 32'(out_ch), 32'h0);

    // Round-robin fairness, no bubbles
    rst_n = 1'b1;
    cycle("rr0", 4'b0001, 1'b0);
    cycle("rr1", 4'b0010, 1'b1);
    cycle("rr2", 4'b0100, 1'b1);
    cycle("rr3", 4'b1000, 1'b1);
    cycle("rr4", 4'b0001, 1'b1);

    // Sparse channels 1 and 3; a grant to 3 wraps ptr to 0
    in_valid = 4'b1010;
    cycle("sp0", 4'b0010, 1'b1);
    cycle("sp1", 4'b1000, 1'b1);
    cycle("sp2", 4'b0010, 1'b1);
    cycle("sp3", 4'b1000, 1'b1);
    in_valid = 4'b1111;
    cycle("wrap", 4'b0001, 1'b1);

    // Fixed select of channel 2, then channel 2 goes idle
    mode = 1'b1;
    sel  = 2'd2;
    cycle("fx0", 4'b0100, 1'b1);
    cycle("fx1", 4'b0100, 1'b1);
    cycle("fx2", 4'b0100, 1'b1);
    in_valid = 4'b1011;
    cycle("fx_idle0", 4'b0000, 1'b1);
    cycle("fx_idle1", 4'b0000, 1'b0);

    // Backpressure: ptr is 3 after the last fixed grant to channel 2
    mode     = 1'b0;
    in_valid = 4'b1111;
    cycle("bp_load", 4'b1000, 1'b0);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle("bp_hold", 4'b0000, 1'b1);
      chk("bp_hold out_data", 32'(out_data), 32'hA3);
      chk("bp_hold out_ch", 32'(out_ch), 32'd3);
    end
    out_ready = 1'b1;
    cycle("bp_release", 4'b0001, 1'b1);

    // Mid-stream reset discards the held beat and clears ptr
    out_ready = 1'b0;
    rst_n     = 1'b0;
    cycle("mid_rst", 4'b0000, 1'b1);
    sb.delete();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    cycle("post_rst0", 4'b0001, 1'b0);
    cycle("post_rst1", 4'b0010, 1'b1);
    in_valid = 4'b0000;
    cycle("drain0", 4'b0000, 1'b1);
    cycle("drain1", 4'b0000, 1'b0);
    chk("sb empty at end", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
